// File: rtl/audio_proc_pkg.sv
// Shared definitions for the audio stream processor: mode encodings,
// FSM state type/constants and the tone half-period helper.
package audio_proc_pkg;

  // Operating modes as presented on the mode input
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_ECHO = 2'd1;
  localparam logic [1:0] MODE_MUTE = 2'd2;
  localparam logic [1:0] MODE_TONE = 2'd3;

  // FSM state type with legacy-compatible constant encodings
  typedef logic [2:0] state_t;
  localparam state_t ST_CLR  = 3'd0;
  localparam state_t ST_IDLE = 3'd1;
  localparam state_t ST_CAP  = 3'd2;
  localparam state_t ST_MIX  = 3'd3;
  localparam state_t ST_WR   = 3'd4;

  // Tone half period is (tone_sel + 1) * TONE_HALF_MULT samples
  localparam int unsigned TONE_HALF_MULT = 8;

  // Half period in samples; the largest value (16 * 8 = 128) fits in 8 bits
  function automatic logic [7:0] tone_half(input logic [3:0] sel);
    return 8'((32'(sel) + 32'd1) * TONE_HALF_MULT);
  endfunction

endpackage

// File: rtl/audio_delay_ram.sv
// Simple dual-port delay RAM for the echo path. Each word packs the left
// channel in the upper half and the right channel in the lower half.
// Read data is registered (one-cycle latency); no read/write bypass.
module audio_delay_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [2*DATA_W-1:0] rdata
);

  logic [2*DATA_W-1:0] mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_stream_proc.sv
// Stereo per-sample processor between the audio input and output FIFO
// handshakes. Modes: passthrough, feedback echo, mute, square tone.
// Optional feature macro: AUDIO_STREAM_PROC_ECHO_EN builds the delay RAM,
// its clear sweep and echo mode; without it mode 1 acts as passthrough and
// reset goes straight to IDLE.
module audio_stream_proc
  import audio_proc_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int TONE_AMP = 10000000
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic [1:0]        mode,
  input  logic [3:0]        tone_sel,
  input  logic              audio_in_available,
  input  logic [DATA_W-1:0] left_channel_audio_in,
  input  logic [DATA_W-1:0] right_channel_audio_in,
  input  logic              audio_out_allowed,
  output logic              read_audio_in,
  output logic [DATA_W-1:0] left_channel_audio_out,
  output logic [DATA_W-1:0] right_channel_audio_out,
  output logic              write_audio_out,
  output logic              busy
);

  localparam logic [DATA_W-1:0] TONE_POS = DATA_W'(TONE_AMP);
  localparam logic [DATA_W-1:0] TONE_NEG = -TONE_POS;

`ifdef AUDIO_STREAM_PROC_ECHO_EN
  localparam state_t RESET_STATE = ST_CLR;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t            state;
  logic [1:0]        mode_q;
  logic [3:0]        tsel_q;
  logic [3:0]        tsel_prev;
  logic [DATA_W-1:0] in_l;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] out_l;
  logic [DATA_W-1:0] out_r;
  logic [DATA_W-1:0] mix_l;
  logic [DATA_W-1:0] mix_r;
  logic [7:0]        tcnt;
  logic [7:0]        tcnt_next;
  logic              phase;
  logic              phase_next;

`ifdef AUDIO_STREAM_PROC_ECHO_EN
  logic [ADDR_W-1:0]   ptr;
  logic                ram_we;
  logic                ram_re;
  logic [2*DATA_W-1:0] ram_wdata;
  logic [2*DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0]   d_l;
  logic [DATA_W-1:0]   d_r;

  // Saturating a + (d >>> 1), formed at DATA_W+1 bits then clamped
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] d);
    logic signed [DATA_W:0] ae;
    logic signed [DATA_W:0] de;
    logic signed [DATA_W:0] s;
    ae = $signed({a[DATA_W-1], a});
    de = $signed({d[DATA_W-1], d}) >>> 1;
    s  = ae + de;
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return s[DATA_W-1:0];
  endfunction
`endif

  // Sequencer: clear sweep, wait for both FIFOs, capture, mix, write out
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESET_STATE;
    end else begin
      case (state)
`ifdef AUDIO_STREAM_PROC_ECHO_EN
        ST_CLR:  if (ptr == '1) state <= ST_IDLE;
`endif
        ST_IDLE: if (audio_in_available && audio_out_allowed) state <= ST_CAP;
        ST_CAP:  state <= ST_MIX;
        ST_MIX:  state <= ST_WR;
        ST_WR:   if (audio_out_allowed) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshakes derived from state; write follows allowed so a stall holds it low
  always_comb begin
    read_audio_in   = (state == ST_CAP);
    write_audio_out = (state == ST_WR) && audio_out_allowed;
`ifdef AUDIO_STREAM_PROC_ECHO_EN
    busy            = (state == ST_CLR);
`else
    busy            = 1'b0;
`endif
  end

  // Tone counter next-state: counts accepted samples, restarts on a pitch change
  always_comb begin
    tcnt_next  = ((tsel_q != tsel_prev) ? 8'd0 : tcnt) + 8'd1;
    phase_next = phase;
    if (tcnt_next == tone_half(tsel_q)) begin
      tcnt_next  = 8'd0;
      phase_next = ~phase;
    end
  end

  // Per-channel sample computation for the latched mode
  always_comb begin
    mix_l = in_l;
    mix_r = in_r;
    case (mode_q)
      MODE_PASS: begin
        mix_l = in_l;
        mix_r = in_r;
      end
      MODE_ECHO: begin
`ifdef AUDIO_STREAM_PROC_ECHO_EN
        mix_l = sat_add(in_l, d_l);
        mix_r = sat_add(in_r, d_r);
`else
        mix_l = in_l;
        mix_r = in_r;
`endif
      end
      MODE_MUTE: begin
        mix_l = '0;
        mix_r = '0;
      end
      MODE_TONE: begin
        if (tsel_q == 4'd0) begin
          mix_l = '0;
        end else begin
          mix_l = phase ? TONE_POS : TONE_NEG;
        end
        mix_r = mix_l;
      end
      default: begin
        mix_l = in_l;
        mix_r = in_r;
      end
    endcase
  end

  // Capture inputs/controls in CAP; register outputs and tone state in MIX
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      in_l      <= '0;
      in_r      <= '0;
      mode_q    <= MODE_PASS;
      tsel_q    <= '0;
      tsel_prev <= '0;
      out_l     <= '0;
      out_r     <= '0;
      tcnt      <= '0;
      phase     <= 1'b0;
    end else if (state == ST_CAP) begin
      in_l   <= left_channel_audio_in;
      in_r   <= right_channel_audio_in;
      mode_q <= mode;
      tsel_q <= tone_sel;
    end else if (state == ST_MIX) begin
      out_l     <= mix_l;
      out_r     <= mix_r;
      tcnt      <= tcnt_next;
      phase     <= phase_next;
      tsel_prev <= tsel_q;
    end
  end

  assign left_channel_audio_out  = out_l;
  assign right_channel_audio_out = out_r;

`ifdef AUDIO_STREAM_PROC_ECHO_EN
  // Delay pointer: advances once per clear-sweep cycle and once per sample
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (state == ST_CLR || state == ST_MIX) begin
      ptr <= ptr + 1'b1;
    end
  end

  // RAM port control: zero-fill during the sweep, feedback write in echo only
  always_comb begin
    ram_re    = (state == ST_CAP);
    ram_we    = (state == ST_CLR) || (state == ST_MIX && mode_q == MODE_ECHO);
    ram_wdata = (state == ST_CLR) ? '0 : {mix_l, mix_r};
    d_l       = ram_rdata[2*DATA_W-1:DATA_W];
    d_r       = ram_rdata[DATA_W-1:0];
  end

  audio_delay_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_delay_ram (
    .clk   (CLOCK_50),
    .we    (ram_we),
    .waddr (ptr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ptr),
    .rdata (ram_rdata)
  );
`endif

endmodule

// File: tb/tb_audio_stream_proc.sv
// Directed self-checking bench for audio_stream_proc (ADDR_W=4).
// Echo-specific steps are built only when AUDIO_STREAM_PROC_ECHO_EN is defined.
module tb_audio_stream_proc;

  localparam logic [31:0] AMP_P = 32'h0098_9680;  // +10000000
  localparam logic [31:0] AMP_N = 32'hFF67_6980;  // -10000000
`ifdef AUDIO_STREAM_PROC_ECHO_EN
  localparam logic [31:0] BUSY_RST = 32'd1;
  localparam int          SWEEP    = 16;
`else
  localparam logic [31:0] BUSY_RST = 32'd0;
  localparam int          SWEEP    = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [3:0]  tone_sel;
  logic        avail;
  logic [31:0] lin;
  logic [31:0] rin;
  logic        allowed;
  logic        rd;
  logic [31:0] lout;
  logic [31:0] rout;
  logic        wr;
  logic        busy;

  int tests = 0;
  int fails = 0;

  audio_stream_proc #(
    .DATA_W   (32),
    .ADDR_W   (4),
    .TONE_AMP (10000000)
  ) dut (
    .CLOCK_50                (clk),
    .reset_n                 (rst_n),
    .mode                    (mode),
    .tone_sel                (tone_sel),
    .audio_in_available      (avail),
    .left_channel_audio_in   (lin),
    .right_channel_audio_in  (rin),
    .audio_out_allowed       (allowed),
    .read_audio_in           (rd),
    .left_channel_audio_out  (lout),
    .right_channel_audio_out (rout),
    .write_audio_out         (wr),
    .busy                    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    avail = 1'b0; allowed = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready", {31'd0, busy}, 32'd0);
  endtask

  // One full sample transaction with bounded waits on both handshakes
  task automatic run_sample(input string tag, input logic [1:0] m, input logic [3:0] ts,
                            input logic [31:0] l, input logic [31:0] r,
                            input logic [31:0] el, input logic [31:0] er);
    int n;
    @(negedge clk);
    mode = m; tone_sel = ts; lin = l; rin = r; avail = 1'b1; allowed = 1'b1;
    n = 0;
    while (!rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rd"}, {31'd0, rd}, 32'd1);
    avail = 1'b0;
    n = 0;
    while (!wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wr"}, {31'd0, wr}, 32'd1);
    chk({tag, "_l"}, lout, el);
    chk({tag, "_r"}, rout, er);
  endtask

  initial begin
    int n;
    mode = 2'd0; tone_sel = 4'd0; lin = '0; rin = '0;
    avail = 1'b0; allowed = 1'b0; rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, BUSY_RST);
    chk("rst_hs", {30'd0, rd, wr}, 32'd0);
    chk("rst_l", lout, 32'd0);
    chk("rst_r", rout, 32'd0);

    // Clear sweep with both FIFOs ready: no handshake while busy
    avail = 1'b1; allowed = 1'b1; rst_n = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      chk("sweep_hs", {30'd0, rd, wr}, 32'd0);
      @(negedge clk);
      n++;
    end
    avail = 1'b0;
    chk("sweep_len", 32'(n), 32'(SWEEP));

    // Pass mode with exact latency
    @(negedge clk);
    mode = 2'd0; lin = 32'h0000_1234; rin = 32'hFFFF_FFFB; avail = 1'b1; allowed = 1'b1;
    @(negedge clk);
    chk("lat_rd1", {30'd0, rd, wr}, 32'd2);
    avail = 1'b0;
    @(negedge clk);
    chk("lat_mix", {30'd0, rd, wr}, 32'd0);
    @(negedge clk);
    chk("lat_wr", {30'd0, rd, wr}, 32'd1);
    chk("pass_l", lout, 32'h0000_1234);
    chk("pass_r", rout, 32'hFFFF_FFFB);
    @(negedge clk);
    chk("lat_wr_once", {30'd0, rd, wr}, 32'd0);

    // Stall in WR for 5 cycles
    mode = 2'd0; lin = 32'h0000_AAAA; rin = 32'h0000_5555; avail = 1'b1; allowed = 1'b1;
    n = 0;
    while (!rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rd", {31'd0, rd}, 32'd1);
    avail = 1'b0; allowed = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wr", {31'd0, wr}, 32'd0);
      chk("stall_l", lout, 32'h0000_AAAA);
      chk("stall_r", rout, 32'h0000_5555);
    end
    allowed = 1'b1;
    #1;
    chk("stall_rel_wr", {31'd0, wr}, 32'd1);
    chk("stall_rel_l", lout, 32'h0000_AAAA);
    @(negedge clk);
    chk("stall_one_wr", {30'd0, rd, wr}, 32'd0);

    // Mute
    run_sample("mute", 2'd2, 4'd0, 32'h1111_1111, 32'h2222_2222, 32'd0, 32'd0);

`ifdef AUDIO_STREAM_PROC_ECHO_EN
    // Echo saturation: positive and negative clamp through a 16-sample lap
    do_reset();
    wait_ready();
    run_sample("sat0", 2'd1, 4'd0, 32'h7FFF_FFFE, 32'h8000_0002, 32'h7FFF_FFFE, 32'h8000_0002);
    for (int i = 1; i < 16; i++)
      run_sample("sat_z", 2'd1, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    run_sample("sat16", 2'd1, 4'd0, 32'h7FFF_FFF0, 32'h8000_0010, 32'h7FFF_FFFF, 32'h8000_0000);

    // Echo impulse decays by half per lap
    do_reset();
    wait_ready();
    for (int i = 0; i <= 32; i++) begin
      logic [31:0] e;
      e = (i == 0) ? 32'd1000 : (i == 16) ? 32'd500 : (i == 32) ? 32'd250 : 32'd0;
      run_sample("echo", 2'd1, 4'd0, (i == 0) ? 32'd1000 : 32'd0,
                 (i == 0) ? 32'd1000 : 32'd0, e, e);
    end
`else
    // Without the echo build, mode 1 is passthrough
    run_sample("m1pass", 2'd1, 4'd0, 32'h0000_0777, 32'hFFFF_F000, 32'h0000_0777, 32'hFFFF_F000);
`endif

    // Reset asserted mid-MIX: aborted sample, no write pulse
    @(negedge clk);
    mode = 2'd0; lin = 32'h0BAD_0BAD; rin = 32'h0000_0042; avail = 1'b1; allowed = 1'b1;
    n = 0;
    while (!rd && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_rd", {31'd0, rd}, 32'd1);
    avail = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_wr0", {31'd0, wr}, 32'd0);
    chk("abort_l", lout, 32'd0);
    chk("abort_busy", {31'd0, busy}, BUSY_RST);
    repeat (3) begin
      @(negedge clk);
      chk("abort_wr", {31'd0, wr}, 32'd0);
    end
    rst_n = 1'b1;
    wait_ready();
    run_sample("recover", 2'd0, 4'd0, 32'h0000_00AB, 32'h0000_00CD, 32'h0000_00AB, 32'h0000_00CD);

    // Tone: 16 mute samples at tone_sel=1 complete the first (negative) half
    do_reset();
    wait_ready();
    for (int i = 0; i < 16; i++)
      run_sample("prime", 2'd2, 4'd1, 32'd5, 32'd5, 32'd0, 32'd0);
    for (int i = 0; i < 16; i++)
      run_sample("tone_hi", 2'd3, 4'd1, 32'd0, 32'd0, AMP_P, AMP_P);
    for (int i = 0; i < 16; i++)
      run_sample("tone_lo", 2'd3, 4'd1, 32'd0, 32'd0, AMP_N, AMP_N);
    run_sample("tone_rep", 2'd3, 4'd1, 32'd0, 32'd0, AMP_P, AMP_P);
    run_sample("tone_off", 2'd3, 4'd0, 32'h1234_5678, 32'd9, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
